// File: rtl/pwm_capture.sv
// pwm_capture -- input-capture peripheral for an external PWM waveform.
//
// Synchronises pwm_in through two flops, detects edges on the synchronised
// level, and times the period (rising edge to rising edge) and the high time
// in clk cycles.  One measurement per PWM cycle is presented with a
// valid/ack handshake.  Counters saturate at 2^CNT_W-1, which raises the
// sticky timeout flag (stuck input, 0% or 100% duty).
//
// Optional build macro: PWM_CAP_FILTER_EN
//   defined   -> glitch filter after the synchroniser; the accepted level
//                changes only after FILTER_LEN consecutive differing cycles.
//   undefined -> synchronised level drives edge detection directly.
//
// Ports
//   clk         system clock (only clock domain)
//   rst_n       asynchronous active-low reset
//   enable      1 = capture running; 0 = FSM idle, counter cleared
//   pwm_in      asynchronous PWM input
//   meas_ack    consumer has taken the measurement; clears meas_valid
//   clr_flags   one-cycle pulse clearing overrun and timeout
//   period_out  cycles between the last two accepted rising edges
//   high_out    cycles high within that period
//   meas_valid  new measurement available
//   overrun     sticky: unacknowledged measurement was overwritten
//   timeout     sticky: counter saturated without an edge
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic             meas_ack,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             lvl;
  logic             lvl_dly_q, lvl_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic rise, fall, cnt_sat, capture, ov_set, to_set;

  always_comb begin
    s1_d      = pwm_in;
    s2_d      = s1_q;
    lvl_dly_d = lvl;
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             filt_q, filt_d;
  logic [FLT_W-1:0] fcnt_q, fcnt_d;

  // The run counter restarts whenever s2 agrees with the accepted level, so
  // only an uninterrupted run of FILTER_LEN differing cycles flips it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (s2_q != filt_q) begin
      if (fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_d = s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN > 0);
  assign lvl = s2_q;
`endif

  assign rise    = lvl & ~lvl_dly_q;
  assign fall    = ~lvl & lvl_dly_q;
  assign cnt_sat = &cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_lat_d = high_lat_q;
    period_d   = period_q;
    high_d     = high_q;
    capture    = 1'b0;
    to_set     = 1'b0;
    ov_set     = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // First rising edge only starts timing; nothing to report yet.
          cnt_d = '0;
          if (rise) begin
            cnt_d   = CNT_W'(1);
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (cnt_sat) begin
            to_set  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (fall) begin
              high_lat_d = cnt_q;
              state_d    = ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (cnt_sat) begin
            to_set  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (rise) begin
            // The edge cycle itself is the first cycle of the next period.
            capture  = 1'b1;
            period_d = cnt_q;
            high_d   = high_lat_q;
            cnt_d    = CNT_W'(1);
            state_d  = ST_HIGH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    valid_d = valid_q;
    if (capture) begin
      valid_d = 1'b1;
      ov_set  = valid_q & ~meas_ack;
    end else if (meas_ack) begin
      valid_d = 1'b0;
    end

    // A new flag event wins over a simultaneous clear.
    overrun_d = ov_set | (overrun_q & ~clr_flags);
    timeout_d = to_set | (timeout_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      lvl_dly_q  <= 1'b0;
      cnt_q      <= '0;
      high_lat_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lvl_dly_q  <= lvl_dly_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = valid_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture (CNT_W=8, FILTER_LEN=3).
// A time-stamp model (rise/fall cycle numbers and plain subtraction) predicts
// every output each cycle; directed literal checks pin the model.
module tb_pwm_capture;

  localparam int CW   = 8;
  localparam int FL   = 3;
  localparam int MAXC = (1 << CW) - 1;
`ifdef PWM_CAP_FILTER_EN
  localparam int LAT = 3 + FL;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          pwm_in;
  logic          meas_ack;
  logic          clr_flags;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;
  logic          meas_valid;
  logic          overrun;
  logic          timeout;

  pwm_capture #(.CNT_W(CW), .FILTER_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .meas_ack   (meas_ack),
    .clr_flags  (clr_flags),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_HIGH, M_LOW} mph_t;
  mph_t m_ph;
  int   m_cyc, m_rise_at, m_fall_at, m_el;
  bit   m_acc, m_acc_prev, m_rise, m_fall, m_cap, m_sov, m_sto, m_win;
  bit   pq[$];
  int   exp_period, exp_high;
  bit   exp_valid, exp_ovr, exp_to;

  task automatic model_reset();
    m_ph = M_IDLE; m_cyc = 0; m_rise_at = 0; m_fall_at = 0;
    m_acc = 0; m_acc_prev = 0;
    pq.delete();
    for (int i = 0; i < 16; i++) pq.push_back(1'b0);
    exp_period = 0; exp_high = 0; exp_valid = 0; exp_ovr = 0; exp_to = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_cyc++;
        pq.push_front(pwm_in);
        void'(pq.pop_back());
        m_rise = m_acc && !m_acc_prev;
        m_fall = !m_acc && m_acc_prev;
        m_cap = 0; m_sov = 0; m_sto = 0;
        m_el = m_cyc - m_rise_at;
        if (!enable) begin
          m_ph = M_IDLE;
        end else begin
          case (m_ph)
            M_IDLE: if (m_rise) begin m_ph = M_HIGH; m_rise_at = m_cyc; end
            M_HIGH: begin
              if (m_el == MAXC) begin m_sto = 1; m_ph = M_IDLE; end
              else if (m_fall) begin m_fall_at = m_cyc; m_ph = M_LOW; end
            end
            default: begin
              if (m_el == MAXC) begin m_sto = 1; m_ph = M_IDLE; end
              else if (m_rise) begin
                exp_period = m_el;
                exp_high   = m_fall_at - m_rise_at;
                m_cap      = 1;
                m_rise_at  = m_cyc;
                m_ph       = M_HIGH;
              end
            end
          endcase
        end
        if (m_cap) begin
          m_sov = exp_valid && !meas_ack;
          exp_valid = 1;
        end else if (meas_ack) begin
          exp_valid = 0;
        end
        exp_ovr = m_sov || (exp_ovr && !clr_flags);
        exp_to  = m_sto || (exp_to && !clr_flags);
        m_acc_prev = m_acc;
`ifdef PWM_CAP_FILTER_EN
        m_win = 1;
        for (int k = 0; k < FL; k++) if (pq[2 + k] == m_acc) m_win = 0;
        if (m_win) m_acc = !m_acc;
`else
        m_acc = pq[1];
`endif
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_period", int'(period_out), exp_period);
        chk("cyc_high",   int'(high_out),   exp_high);
        chk("cyc_valid",  int'(meas_valid), int'(exp_valid));
        chk("cyc_ovr",    int'(overrun),    int'(exp_ovr));
        chk("cyc_to",     int'(timeout),    int'(exp_to));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int n;
  initial begin
    rst_n = 1; enable = 0; pwm_in = 0; meas_ack = 0; clr_flags = 0;
    #1 rst_n = 0;
    tick(3);
    rst_n = 1;
    chk_en = 1;
    chk("rst_period", int'(period_out), 0);
    chk("rst_high",   int'(high_out), 0);
    chk("rst_valid",  int'(meas_valid), 0);
    chk("rst_ovr",    int'(overrun), 0);
    chk("rst_to",     int'(timeout), 0);
    enable = 1;
    tick(5);

    // 1: P=100, H=30
    pwm_in = 1; tick(30); pwm_in = 0; tick(70);
    chk("t1_no_valid_first", int'(meas_valid), 0);
    pwm_in = 1; n = 0;
    while (!meas_valid && n < 20) begin tick(1); n++; end
    chk("t1_latency", n, LAT);
    chk("t1_period", int'(period_out), 100);
    chk("t1_high", int'(high_out), 30);
    meas_ack = 1; tick(1); meas_ack = 0;
    chk("t1_ack_clears", int'(meas_valid), 0);
    tick(29 - n); pwm_in = 0; tick(70);
    pwm_in = 1; tick(30); pwm_in = 0; tick(35);
    meas_ack = 1; tick(1); meas_ack = 0; tick(34);

    // 2: no ack -> overrun after second capture; ack on capture -> none
    pwm_in = 1; tick(30); pwm_in = 0; tick(70);
    chk("t2_valid_first", int'(meas_valid), 1);
    chk("t2_no_ovr_first", int'(overrun), 0);
    pwm_in = 1; tick(30);
    chk("t2_ovr", int'(overrun), 1);
    chk("t2_period", int'(period_out), 100);
    pwm_in = 0; tick(69); clr_flags = 1; tick(1); clr_flags = 0;
    chk("t2_clr", int'(overrun), 0);
    pwm_in = 1; tick(LAT - 1); meas_ack = 1; tick(1); meas_ack = 0;
    chk("t2_ack_cap_valid", int'(meas_valid), 1);
    chk("t2_ack_cap_no_ovr", int'(overrun), 0);
    tick(30 - LAT); pwm_in = 0; tick(70);

    // 3: stuck high -> timeout at cnt=255
    rst_n = 0; tick(2); rst_n = 1;
    tick(5);
    pwm_in = 1; tick(LAT + MAXC - 1);
    chk("t3_to_before", int'(timeout), 0);
    tick(1);
    chk("t3_to_set", int'(timeout), 1);
    chk("t3_no_valid", int'(meas_valid), 0);
    tick(300 - LAT - MAXC);
    clr_flags = 1; tick(1); clr_flags = 0;
    chk("t3_to_clr", int'(timeout), 0);
    pwm_in = 0; tick(20);

    // 4: reset during HIGH
    pwm_in = 1; tick(30); pwm_in = 0; tick(70);
    pwm_in = 1; tick(30); pwm_in = 0; tick(70);
    pwm_in = 1; tick(10);
    chk("t4_valid_pre", int'(meas_valid), 1);
    rst_n = 0; #1;
    chk("t4_rst_period", int'(period_out), 0);
    chk("t4_rst_high", int'(high_out), 0);
    chk("t4_rst_valid", int'(meas_valid), 0);
    tick(2); rst_n = 1;
    tick(20); pwm_in = 0; tick(70);
    chk("t4_no_valid_first_rise", int'(meas_valid), 0);
    pwm_in = 1; tick(30); pwm_in = 0; tick(70);
    pwm_in = 1; tick(LAT);
    chk("t4_full_period", int'(period_out), 100);
    chk("t4_full_high", int'(high_out), 30);
    meas_ack = 1; tick(1); meas_ack = 0;
    tick(29 - LAT); pwm_in = 0; tick(70);

    // 5: 2-cycle low glitch inside the high phase
    pwm_in = 1; tick(10); pwm_in = 0; tick(2); pwm_in = 1; tick(18);
    pwm_in = 0; tick(70);
`ifdef PWM_CAP_FILTER_EN
    chk("t5_glitch_period", int'(period_out), 100);
    chk("t5_glitch_high", int'(high_out), 30);
`else
    chk("t5_glitch_period", int'(period_out), 12);
    chk("t5_glitch_high", int'(high_out), 10);
`endif
    pwm_in = 1; tick(LAT);
`ifdef PWM_CAP_FILTER_EN
    chk("t5_next_high", int'(high_out), 30);
`else
    chk("t5_next_high", int'(high_out), 18);
`endif
    meas_ack = 1; tick(1); meas_ack = 0;
    tick(29 - LAT); pwm_in = 0; tick(70);

    // 6: enable dropped mid-LOW
    pwm_in = 1; tick(30); pwm_in = 0; tick(30);
    meas_ack = 1; tick(1); meas_ack = 0;
    enable = 0; tick(40);
    chk("t6_held_period", int'(period_out), 100);
    chk("t6_held_high", int'(high_out), 30);
    chk("t6_held_valid", int'(meas_valid), 0);
    enable = 1; tick(5);
    pwm_in = 1; tick(30);
    chk("t6_no_capture", int'(meas_valid), 0);
    chk("t6_period_kept", int'(period_out), 100);
    pwm_in = 0; tick(50);
    pwm_in = 1; tick(LAT);
    chk("t6_valid", int'(meas_valid), 1);
    chk("t6_period", int'(period_out), 80);
    chk("t6_high", int'(high_out), 30);
    tick(10);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
